interrupt_request_service_8259: RTL and testbench

- Upstream stage of the 8259A control logic.
- Samples IR0-IR7 pins into the Interrupt Request Register (IRR) in edge or level mode, and holds the In-Service Register (ISR).
- Resolves rotating priority under mask, special-mask and fully-nested rules.
- Drives the one-hot `interrupt` winner and `highest_level_in_service` that the control logic consumes.
- Consumes the control logic's mask, EOI, rotate, freeze, latch and clear signals.

---
 rtl/interrupt_request_service_8259_pkg.sv | 23 ++
 rtl/interrupt_request_service_8259_if.sv | 37 +++
 rtl/interrupt_request_service_8259_priority_resolver.sv | 14 +
 rtl/interrupt_request_service_8259.sv | 84 ++++++++
 tb/tb_interrupt_request_service_8259.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/interrupt_request_service_8259_pkg.sv
// Shared constants and bit-vector helpers for the 8259 request/service stage.
// Rotations let the priority logic always work with the highest level at bit 0.
package pic8259_pkg;

  localparam int IR_COUNT = 8;

  function automatic logic [7:0] rotate_right_8(input logic [7:0] vec, input logic [2:0] n);
    logic [15:0] dbl;
    dbl = {vec, vec} >> n;
    return dbl[7:0];
  endfunction

  function automatic logic [7:0] rotate_left_8(input logic [7:0] vec, input logic [2:0] n);
    logic [15:0] dbl;
    dbl = {vec, vec} << n;
    return dbl[15:8];
  endfunction

  function automatic logic [7:0] isolate_lowest_bit(input logic [7:0] vec);
    return vec & (~vec + 8'd1);
  endfunction

endpackage

// File: rtl/interrupt_request_service_8259_if.sv
// Bundle between the 8259 control logic (master) and the request/service stage (slave).
// The raw IR pins ride along so the stage has a single bus port.
interface interrupt_request_service_8259_if;
  logic [7:0] interrupt_request_pin;
  logic       write_initial_command_word_1;
  logic       level_or_edge_toriggered_config;
  logic       special_fully_nest_config;
  logic       freeze;
  logic [7:0] clear_interrupt_request;
  logic [7:0] interrupt_mask;
  logic [7:0] interrupt_special_mask;
  logic [2:0] priority_rotate;
  logic       latch_in_service;
  logic [7:0] end_of_interrupt;
  logic [7:0] interrupt;
  logic [7:0] highest_level_in_service;
  logic [7:0] interrupt_request_register;
  logic [7:0] in_service_register;

  modport slave (
    input  interrupt_request_pin, write_initial_command_word_1,
           level_or_edge_toriggered_config, special_fully_nest_config, freeze,
           clear_interrupt_request, interrupt_mask, interrupt_special_mask,
           priority_rotate, latch_in_service, end_of_interrupt,
    output interrupt, highest_level_in_service, interrupt_request_register,
           in_service_register
  );

  modport master (
    output interrupt_request_pin, write_initial_command_word_1,
           level_or_edge_toriggered_config, special_fully_nest_config, freeze,
           clear_interrupt_request, interrupt_mask, interrupt_special_mask,
           priority_rotate, latch_in_service, end_of_interrupt,
    input  interrupt, highest_level_in_service, interrupt_request_register,
           in_service_register
  );
endinterface

// File: rtl/interrupt_request_service_8259_priority_resolver.sv
// Combinational rotating-priority pick: one-hot highest-priority set bit of request.
// Highest priority level is priority_rotate+1 (mod 8).
module priority_resolver_8259 (
  input  logic [7:0] request,
  input  logic [2:0] priority_rotate,
  output logic [7:0] highest
);
  import pic8259_pkg::*;

  logic [2:0] shift;

  assign shift   = priority_rotate + 3'd1;
  assign highest = rotate_left_8(isolate_lowest_bit(rotate_right_8(request, shift)), shift);
endmodule

// File: rtl/interrupt_request_service_8259.sv
// 8259A request/service stage: IR synchronizers, IRR, ISR and the registered
// one-hot interrupt winner under mask, special-mask and nesting rules.
module interrupt_request_service_8259 #(
  parameter int SYNC_STAGES = 2
) (
  input logic                              clock,
  input logic                              reset,
  interrupt_request_service_8259_if.slave  irq
);
  import pic8259_pkg::*;

  logic [SYNC_STAGES-1:0][IR_COUNT-1:0] sync_q;
  logic [IR_COUNT-1:0] prev_q, irr_q, irr_d, isr_q, isr_d, interrupt_q, interrupt_d;
  logic [IR_COUNT-1:0] sync_w, nest_level, nest_rot, allowed_rot, eligible;
  logic [2:0]          shift;

  assign sync_w = sync_q[SYNC_STAGES-1];

  // ICW1 deliberately leaves the synchronizers running; only reset clears them.
  always_ff @(posedge clock) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], irq.interrupt_request_pin};
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    irr_d = irr_q;
    for (int i = 0; i < IR_COUNT; i++) begin
      if (irq.clear_interrupt_request[i])          irr_d[i] = 1'b0;
      else if (irq.freeze)                         irr_d[i] = irr_q[i];
      else if (irq.level_or_edge_toriggered_config) irr_d[i] = sync_w[i];
      else if (sync_w[i] & ~prev_q[i])             irr_d[i] = 1'b1;
      else if (~sync_w[i])                         irr_d[i] = 1'b0;
    end
  end

  // Latch is OR-ed after the EOI clear, so a same-cycle latch wins.
  assign isr_d = (isr_q & ~irq.end_of_interrupt) |
                 (irq.latch_in_service ? interrupt_q : '0);

  priority_resolver_8259 u_nest_resolver (
    .request         (isr_q & ~irq.interrupt_special_mask),
    .priority_rotate (irq.priority_rotate),
    .highest         (nest_level)
  );

  // In the rotated domain, "strictly higher priority" is every bit below the nest bit.
  assign shift    = irq.priority_rotate + 3'd1;
  assign nest_rot = rotate_right_8(nest_level, shift);

  always_comb begin
    allowed_rot = '1;
    if (nest_rot != '0)
      allowed_rot = (nest_rot - 8'd1) | (irq.special_fully_nest_config ? nest_rot : '0);
  end

  assign eligible = irr_q & ~irq.interrupt_mask & rotate_left_8(allowed_rot, shift);

  priority_resolver_8259 u_request_resolver (
    .request         (eligible),
    .priority_rotate (irq.priority_rotate),
    .highest         (interrupt_d)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (reset || irq.write_initial_command_word_1) begin
      prev_q      <= '0;
      irr_q       <= '0;
      isr_q       <= '0;
      interrupt_q <= '0;
    end else begin
      prev_q      <= sync_w;
      irr_q       <= irr_d;
      isr_q       <= isr_d;
      interrupt_q <= interrupt_d;
    end
  end

  assign irq.interrupt                  = interrupt_q;
  assign irq.highest_level_in_service   = nest_level;
  assign irq.interrupt_request_register = irr_q;
  assign irq.in_service_register        = isr_q;
endmodule

// File: tb/tb_interrupt_request_service_8259.sv
// Self-checking bench: directed scenarios plus randomized traffic compared every
// cycle against a rank-based behavioural model of the request/service stage.
module tb_interrupt_request_service_8259;
  localparam int SYNC_STAGES = 2;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  interrupt_request_service_8259_if bus ();

  interrupt_request_service_8259 #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clock (clock),
    .reset (reset),
    .irq   (bus)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  logic [7:0] m_sync [0:3];
  logic [7:0] m_prev, m_irr, m_isr, m_intr;

  function automatic int rank(input int lvl, input logic [2:0] rot);
    return (lvl + 7 - int'(rot)) % 8;
  endfunction

  function automatic logic [7:0] m_resolve(input logic [7:0] req, input logic [2:0] rot);
    int best = -1;
    for (int i = 0; i < 8; i++)
      if (req[i] && (best < 0 || rank(i, rot) < rank(best, rot))) best = i;
    return (best < 0) ? 8'h00 : (8'h01 << best);
  endfunction

  function automatic logic [7:0] m_hlis();
    return m_resolve(m_isr & ~bus.interrupt_special_mask, bus.priority_rotate);
  endfunction

  function automatic logic [7:0] m_eligible();
    logic [7:0] nest = m_hlis();
    logic [7:0] el = 8'h00;
    int nl = 0;
    for (int i = 0; i < 8; i++) if (nest[i]) nl = i;
    for (int i = 0; i < 8; i++) begin
      if (m_irr[i] && !bus.interrupt_mask[i]) begin
        if (nest == 8'h00) el[i] = 1'b1;
        else if (rank(i, bus.priority_rotate) < rank(nl, bus.priority_rotate)) el[i] = 1'b1;
        else if (bus.special_fully_nest_config &&
                 rank(i, bus.priority_rotate) == rank(nl, bus.priority_rotate)) el[i] = 1'b1;
      end
    end
    return el;
  endfunction

  always @(posedge clock) begin
    logic [7:0] s, nirr, nisr, nintr, nprev;
    if (reset) begin
      for (int k = 0; k < 4; k++) m_sync[k] = 8'h00;
      m_prev = 8'h00; m_irr = 8'h00; m_isr = 8'h00; m_intr = 8'h00;
    end else begin
      s = m_sync[SYNC_STAGES-1];
      for (int i = 0; i < 8; i++) begin
        if (bus.clear_interrupt_request[i])           nirr[i] = 1'b0;
        else if (bus.freeze)                          nirr[i] = m_irr[i];
        else if (bus.level_or_edge_toriggered_config) nirr[i] = s[i];
        else if (s[i] && !m_prev[i])                  nirr[i] = 1'b1;
        else if (!s[i])                               nirr[i] = 1'b0;
        else                                          nirr[i] = m_irr[i];
      end
      nisr  = (m_isr & ~bus.end_of_interrupt) | (bus.latch_in_service ? m_intr : 8'h00);
      nintr = m_resolve(m_eligible(), bus.priority_rotate);
      nprev = s;
      for (int k = SYNC_STAGES - 1; k > 0; k--) m_sync[k] = m_sync[k-1];
      m_sync[0] = bus.interrupt_request_pin;
      if (bus.write_initial_command_word_1) begin
        nprev = 8'h00; nirr = 8'h00; nisr = 8'h00; nintr = 8'h00;
      end
      m_prev = nprev; m_irr = nirr; m_isr = nisr; m_intr = nintr;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("irr",  bus.interrupt_request_register, m_irr);
    check("isr",  bus.in_service_register, m_isr);
    check("intr", bus.interrupt, m_intr);
    check("hlis", bus.highest_level_in_service, m_hlis());
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
    compare_all();
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    reset = 1'b1;
    bus.interrupt_request_pin           = 8'h00;
    bus.write_initial_command_word_1    = 1'b0;
    bus.level_or_edge_toriggered_config = 1'b0;
    bus.special_fully_nest_config       = 1'b0;
    bus.freeze                          = 1'b0;
    bus.clear_interrupt_request         = 8'h00;
    bus.interrupt_mask                  = 8'h00;
    bus.interrupt_special_mask          = 8'h00;
    bus.priority_rotate                 = 3'd7;
    bus.latch_in_service                = 1'b0;
    bus.end_of_interrupt                = 8'h00;
    repeat (3) @(negedge clock);
    compare_all();
    check("reset_intr", bus.interrupt, 8'h00);
    reset = 1'b0;

    // Edge mode IR3 rise: IRR after SYNC_STAGES+1 clocks, interrupt one later.
    bus.interrupt_request_pin = 8'h08;
    steps(SYNC_STAGES + 1);
    check("edge_irr", bus.interrupt_request_register, 8'h08);
    check("edge_intr_early", bus.interrupt, 8'h00);
    step();
    check("edge_intr", bus.interrupt, 8'h08);
    bus.interrupt_request_pin = 8'h00;
    steps(SYNC_STAGES + 2);
    check("drop_irr", bus.interrupt_request_register, 8'h00);
    check("drop_intr", bus.interrupt, 8'h00);

    // Level mode priority under mask and rotation.
    bus.level_or_edge_toriggered_config = 1'b1;
    bus.interrupt_request_pin = 8'hA4;
    bus.interrupt_mask = 8'h04;
    steps(SYNC_STAGES + 2);
    check("mask_intr", bus.interrupt, 8'h20);
    bus.interrupt_mask = 8'h00;
    bus.priority_rotate = 3'd4;
    step();
    check("rot4_intr", bus.interrupt, 8'h20);
    bus.priority_rotate = 3'd5;
    step();
    check("rot5_intr", bus.interrupt, 8'h80);

    // Nesting: latch IR3, then lower and higher requests.
    bus.priority_rotate = 3'd7;
    bus.interrupt_request_pin = 8'h08;
    steps(SYNC_STAGES + 2);
    bus.latch_in_service = 1'b1;
    step();
    bus.latch_in_service = 1'b0;
    check("nest_isr", bus.in_service_register, 8'h08);
    bus.interrupt_request_pin = 8'h41;
    steps(SYNC_STAGES + 2);
    check("nest_higher", bus.interrupt, 8'h01);
    bus.interrupt_request_pin = 8'h48;
    steps(SYNC_STAGES + 2);
    check("nest_block", bus.interrupt, 8'h00);
    bus.special_fully_nest_config = 1'b1;
    step();
    check("sfnm_equal", bus.interrupt, 8'h08);

    // Latch and EOI on the same bit in the same cycle: latch wins.
    bus.special_fully_nest_config = 1'b0;
    bus.end_of_interrupt = 8'hFF;
    bus.interrupt_request_pin = 8'h04;
    step();
    bus.end_of_interrupt = 8'h00;
    steps(SYNC_STAGES + 2);
    check("race_pre_intr", bus.interrupt, 8'h04);
    bus.latch_in_service = 1'b1;
    bus.end_of_interrupt = 8'h04;
    step();
    check("race_isr", bus.in_service_register, 8'h04);
    bus.latch_in_service = 1'b0;
    step();
    check("eoi_isr", bus.in_service_register, 8'h00);
    bus.end_of_interrupt = 8'h00;

    // Freeze loses edges; clear still works while frozen.
    bus.level_or_edge_toriggered_config = 1'b0;
    bus.interrupt_request_pin = 8'h00;
    steps(SYNC_STAGES + 2);
    bus.freeze = 1'b1;
    bus.interrupt_request_pin = 8'h40;
    steps(SYNC_STAGES + 2);
    check("freeze_irr", bus.interrupt_request_register, 8'h00);
    check("freeze_intr", bus.interrupt, 8'h00);
    bus.freeze = 1'b0;
    steps(2);
    check("lost_edge_irr", bus.interrupt_request_register, 8'h00);
    bus.interrupt_request_pin = 8'h42;
    steps(SYNC_STAGES + 1);
    check("ir1_irr", bus.interrupt_request_register, 8'h02);
    bus.freeze = 1'b1;
    bus.clear_interrupt_request = 8'h02;
    step();
    check("clear_frozen_irr", bus.interrupt_request_register, 8'h00);
    bus.freeze = 1'b0;
    bus.clear_interrupt_request = 8'h00;

    // Reset with a busy IRR and ISR.
    bus.level_or_edge_toriggered_config = 1'b1;
    bus.interrupt_request_pin = 8'hFF;
    bus.latch_in_service = 1'b1;
    steps(SYNC_STAGES + 4);
    bus.latch_in_service = 1'b0;
    reset = 1'b1;
    step();
    check("rst_irr", bus.interrupt_request_register, 8'h00);
    check("rst_isr", bus.in_service_register, 8'h00);
    check("rst_intr", bus.interrupt, 8'h00);
    check("rst_hlis", bus.highest_level_in_service, 8'h00);
    reset = 1'b0;

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      reset = ($urandom_range(399) == 0);
      bus.write_initial_command_word_1 = ($urandom_range(149) == 0);
      if ($urandom_range(199) == 0)
        bus.level_or_edge_toriggered_config = ~bus.level_or_edge_toriggered_config;
      if ($urandom_range(49) == 0) bus.special_fully_nest_config = $urandom_range(1);
      if ($urandom_range(2) == 0)
        bus.interrupt_request_pin = bus.interrupt_request_pin ^ (8'($urandom) & 8'($urandom));
      bus.freeze = ($urandom_range(7) == 0);
      bus.clear_interrupt_request = ($urandom_range(7) == 0) ? (8'h01 << $urandom_range(7)) : 8'h00;
      if ($urandom_range(29) == 0) bus.interrupt_mask = 8'($urandom) & 8'($urandom);
      if ($urandom_range(29) == 0) bus.interrupt_special_mask = 8'($urandom) & 8'($urandom) & 8'($urandom);
      if ($urandom_range(19) == 0) bus.priority_rotate = 3'($urandom_range(7));
      bus.latch_in_service = ($urandom_range(3) == 0);
      bus.end_of_interrupt = ($urandom_range(5) == 0) ? (8'h01 << $urandom_range(7)) : 8'h00;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
